score_uart_reporter: RTL and testbench
======================================

// Module: score_uart_reporter
// PURPOSE
//  Downstream consumer of the central game-control block. It watches the game state and score
//  and, on every game-over, streams an ASCII report "SCORE xx BEST yy\r\n" to the board UART
//  transmitter (txdata/txclk/txready).
//  It keeps the best (lowest) BCD score seen since board reset and flags a new best for an LED.
// PARAMETERS
//  SEND_BEST  1  1: append " BEST yy" (18-byte message); 0: "SCORE xx\r\n" only (10 bytes)
// PORTS
//  clk       in   1  system clock (hz100); single clock domain
//  rst       in   1  synchronous, active-high reset; board reset, not the game-restart button
//  state     in   3  game state from central: 000 idle, 001-110 playing, 111 game over
//  score     in   8  two-digit BCD score from central; valid while state==111
//  txready   in   1  UART transmitter can accept a byte
//  txdata    out  8  byte to transmit; held stable from its txclk pulse until the next load
//  txclk     out  1  one-cycle strobe: transmitter captures txdata
//  busy      out  1  message in progress
//  best      out  8  lowest BCD score since rst
//  new_best  out  1  last completed game set a new best; cleared when state returns to 000
// BEHAVIOUR
//  - Reset values: txdata=8'h00, txclk=0, busy=0, best=8'h99, new_best=0, FSM=IDLE, idx=0,
//    prev_over=1 (suppresses a report if state==111 when rst releases).
//  - Trigger: cycle with state==111 && !prev_over. prev_over <= (state==111) every cycle.
//  - FSM IDLE -> SEND on trigger: latch score into sc_q, set idx=0, busy<=1.
//    Same edge: if score < best (plain unsigned compare, valid for BCD), best<=score and
//    new_best<=1; otherwise new_best<=0. The message carries the updated best.
//  - FSM SEND: if txready, txdata<=msg[idx], txclk<=1, go to GAP. Else hold; txclk stays 0.
//  - FSM GAP (1 cycle): txclk<=0. If idx==LEN-1: busy<=0, go to IDLE. Else idx++, go to SEND.
//  - Timing: first txclk is high 2 cycles after the trigger cycle if txready=1. Minimum byte
//    period is 2 cycles. LEN = 18 (SEND_BEST=1) or 10.
//  - Message bytes: "SCORE " sc_hi sc_lo [" BEST " best_hi best_lo] 8'h0D 8'h0A.
//    Digit byte = 8'h30 + nibble. Non-BCD nibbles are sent unchecked (A-F give ':'-'?').
//  - Triggers while busy are ignored. A new trigger needs state to leave 111 and return.
//  - state==000 in any FSM state clears new_best. It does not abort a message in flight.
//  - rst mid-message: next edge gives all reset values. No further txclk. Partial message is
//    dropped, not resumed.
//  - idx width is 5 bits. It never wraps; it is bounded by LEN-1.
// STRUCTURE
//  - game_pkg: ST_IDLE=3'b000, ST_OVER=3'b111; rpt_state_e {IDLE,SEND,GAP};
//    ASCII constants (CH_S,CH_C,CH_O,CH_R,CH_E,CH_B,CH_T,CH_SP,CH_CR,CH_LF); MSG_LEN_FULL=18,
//    MSG_LEN_SHORT=10.
//  - Sub-module score_msg_rom: combinational (idx, sc_q, best, SEND_BEST) -> byte; holds the
//    message layout and the digit-to-ASCII conversion.
//  - Top: FSM, trigger edge detect, best/new_best registers.
// TESTING
//  1. rst; state 000->001->111 with score=8'h42, txready=1 -> 18 txclk pulses, 2 cycles apart:
//     53 43 4F 52 45 20 34 32 20 42 45 53 54 20 34 32 0D 0A; best=42; new_best=1.
//  2. Drop txready for 5 cycles before byte 3 -> no txclk, txdata holds 4F. Resumes with 52 one
//     cycle after txready returns.
//  3. Game 2 without rst: state 111->000->011->111, score=8'h55 -> "SCORE 55 BEST 42\r\n";
//     best stays 42; new_best=0. new_best is cleared as soon as state==000.
//  4. Assert rst during byte 5 -> next cycle txclk=0, busy=0, best=99; no more pulses while
//     state holds 111.
//  5. state=111 while rst releases -> no txclk for 50 cycles; busy stays 0.
//  6. SEND_BEST=0, score=8'h07 -> 10 bytes: 53 43 4F 52 45 20 30 37 0D 0A.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-state codes, reporter FSM states and ASCII constants for the score UART reporter.
// Digit helper maps one BCD nibble to its ASCII byte.
package game_pkg;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_OVER = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } rpt_state_e;

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam int MSG_LEN_FULL  = 18;
  localparam int MSG_LEN_SHORT = 10;
  localparam int IDX_W         = 5;

  // Non-BCD nibbles are passed through unchecked, so A-F land on ':'..'?'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] nib);
    return 8'h30 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/score_msg_rom.sv
// Combinational message layout: byte index -> ASCII byte of "SCORE xx[ BEST yy]\r\n".
// Zero latency, no state; indices past the message end read as 8'h00.
module score_msg_rom
  import game_pkg::*;
#(
  parameter bit SEND_BEST = 1'b1
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       sc_i,
  input  logic [7:0]       best_i,
  output logic [7:0]       byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      5'd0: byte_o = CH_S;
      5'd1: byte_o = CH_C;
      5'd2: byte_o = CH_O;
      5'd3: byte_o = CH_R;
      5'd4: byte_o = CH_E;
      5'd5: byte_o = CH_SP;
      5'd6: byte_o = digit_ascii(sc_i[7:4]);
      5'd7: byte_o = digit_ascii(sc_i[3:0]);
      default: begin
        if (SEND_BEST) begin
          case (idx_i)
            5'd8:    byte_o = CH_SP;
            5'd9:    byte_o = CH_B;
            5'd10:   byte_o = CH_E;
            5'd11:   byte_o = CH_S;
            5'd12:   byte_o = CH_T;
            5'd13:   byte_o = CH_SP;
            5'd14:   byte_o = digit_ascii(best_i[7:4]);
            5'd15:   byte_o = digit_ascii(best_i[3:0]);
            5'd16:   byte_o = CH_CR;
            5'd17:   byte_o = CH_LF;
            default: byte_o = 8'h00;
          endcase
        end else begin
          case (idx_i)
            5'd8:    byte_o = CH_CR;
            5'd9:    byte_o = CH_LF;
            default: byte_o = 8'h00;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/score_uart_reporter.sv
// Streams "SCORE xx[ BEST yy]\r\n" to the UART on each game-over edge; first txclk 2 cycles
// after the trigger, one byte per 2 cycles minimum; stalls in SEND while txready is low.
module score_uart_reporter
  import game_pkg::*;
#(
  parameter bit SEND_BEST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [7:0] score,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic [7:0] best,
  output logic       new_best
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(SEND_BEST ? MSG_LEN_FULL - 1 : MSG_LEN_SHORT - 1);

  rpt_state_e       st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sc_q, sc_d;
  logic [7:0]       best_q, best_d;
  logic             new_best_q, new_best_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             txclk_q, txclk_d;
  logic             busy_q, busy_d;
  logic             prev_over_q;
  logic             trigger;
  logic [7:0]       rom_byte;

  assign trigger = (state == ST_OVER) && !prev_over_q;

  score_msg_rom #(
    .SEND_BEST(SEND_BEST)
  ) u_rom (
    .idx_i  (idx_q),
    .sc_i   (sc_q),
    .best_i (best_q),
    .byte_o (rom_byte)
  );

  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    sc_d       = sc_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    txdata_d   = txdata_q;
    txclk_d    = 1'b0;
    busy_d     = busy_q;

    case (st_q)
      IDLE: begin
        if (trigger) begin
          st_d   = SEND;
          sc_d   = score;
          idx_d  = '0;
          busy_d = 1'b1;
          // Best is updated on the trigger edge so the message reports the new value.
          if (score < best_q) begin
            best_d     = score;
            new_best_d = 1'b1;
          end else begin
            new_best_d = 1'b0;
          end
        end
      end
      SEND: begin
        if (txready) begin
          txdata_d = rom_byte;
          txclk_d  = 1'b1;
          st_d     = GAP;
        end
      end
      GAP: begin
        if (idx_q == LAST_IDX) begin
          busy_d = 1'b0;
          st_d   = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
          st_d  = SEND;
        end
      end
      default: st_d = IDLE;
    endcase

    if (state == ST_IDLE) new_best_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      idx_q       <= '0;
      sc_q        <= 8'h00;
      best_q      <= 8'h99;
      new_best_q  <= 1'b0;
      txdata_q    <= 8'h00;
      txclk_q     <= 1'b0;
      busy_q      <= 1'b0;
      prev_over_q <= 1'b1;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      sc_q        <= sc_d;
      best_q      <= best_d;
      new_best_q  <= new_best_d;
      txdata_q    <= txdata_d;
      txclk_q     <= txclk_d;
      busy_q      <= busy_d;
      prev_over_q <= (state == ST_OVER);
    end
  end

  assign txdata   = txdata_q;
  assign txclk    = txclk_q;
  assign busy     = busy_q;
  assign best     = best_q;
  assign new_best = new_best_q;

endmodule

// File: tb/tb_score_uart_reporter.sv
// Randomized bench for score_uart_reporter: full- and short-message instances share stimulus,
// each checked against an expected-byte queue built from the message text.
module tb_score_uart_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'b000;
  logic [7:0] score = 8'h00;
  logic       txready = 1'b1;

  logic [7:0] txdata_l, best_l, txdata_s, best_s;
  logic       txclk_l, busy_l, new_best_l, txclk_s, busy_s, new_best_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] q_l[$];
  logic [7:0] q_s[$];
  int         pc_l[$];
  int         n_pulse_l = 0, n_pulse_s = 0;
  int         last_l = -10, last_s = -10;
  int         trig_cyc = 0;

  logic [7:0] m_best = 8'h99;
  logic       m_nb = 1'b0;

  score_uart_reporter #(.SEND_BEST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .state(state), .score(score), .txready(txready),
    .txdata(txdata_l), .txclk(txclk_l), .busy(busy_l), .best(best_l), .new_best(new_best_l)
  );

  score_uart_reporter #(.SEND_BEST(1'b0)) dut_s (
    .clk(clk), .rst(rst), .state(state), .score(score), .txready(txready),
    .txdata(txdata_s), .txclk(txclk_s), .busy(busy_s), .best(best_s), .new_best(new_best_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (txclk_l) begin
      n_pulse_l++;
      pc_l.push_back(cyc);
      if (q_l.size() == 0) chk("spurious_txclk_l", 1, 0);
      else chk("txdata_l", txdata_l, q_l.pop_front());
      chk("spacing_l", ((cyc - last_l) >= 2), 1);
      last_l = cyc;
    end
    if (txclk_s) begin
      n_pulse_s++;
      if (q_s.size() == 0) chk("spurious_txclk_s", 1, 0);
      else chk("txdata_s", txdata_s, q_s.pop_front());
      chk("spacing_s", ((cyc - last_s) >= 2), 1);
      last_s = cyc;
    end
  end

  task automatic build_msg(input logic [7:0] sc, input logic [7:0] bst);
    string head, mid;
    head = "SCORE ";
    mid  = " BEST ";
    for (int i = 0; i < 6; i++) begin
      q_l.push_back(head[i]);
      q_s.push_back(head[i]);
    end
    q_l.push_back(8'h30 + sc[7:4]);  q_s.push_back(8'h30 + sc[7:4]);
    q_l.push_back(8'h30 + sc[3:0]);  q_s.push_back(8'h30 + sc[3:0]);
    for (int i = 0; i < 6; i++) q_l.push_back(mid[i]);
    q_l.push_back(8'h30 + bst[7:4]);
    q_l.push_back(8'h30 + bst[3:0]);
    q_l.push_back(8'h0D);  q_s.push_back(8'h0D);
    q_l.push_back(8'h0A);  q_s.push_back(8'h0A);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_txdata_l"}, txdata_l, 8'h00);
    chk({tag, "_txclk_l"}, txclk_l, 0);
    chk({tag, "_busy_l"}, busy_l, 0);
    chk({tag, "_best_l"}, best_l, 8'h99);
    chk({tag, "_new_best_l"}, new_best_l, 0);
    chk({tag, "_txdata_s"}, txdata_s, 8'h00);
    chk({tag, "_txclk_s"}, txclk_s, 0);
    chk({tag, "_busy_s"}, busy_s, 0);
    chk({tag, "_best_s"}, best_s, 8'h99);
    chk({tag, "_new_best_s"}, new_best_s, 0);
  endtask

  // Drives a playing phase then game-over; caller guarantees both instances are idle.
  task automatic trigger_game(input logic [7:0] sc);
    state = 3'($urandom_range(1, 6));
    repeat ($urandom_range(1, 3)) tick();
    score = sc;
    state = 3'b111;
    trig_cyc = cyc;
    pc_l.delete();
    if (sc < m_best) begin
      m_best = sc;
      m_nb   = 1'b1;
    end else begin
      m_nb = 1'b0;
    end
    build_msg(sc, m_best);
    tick();
    chk("trig_best_l", best_l, m_best);
    chk("trig_best_s", best_s, m_best);
    chk("trig_new_best_l", new_best_l, m_nb);
    chk("trig_new_best_s", new_best_s, m_nb);
    chk("trig_busy_l", busy_l, 1);
    chk("trig_busy_s", busy_s, 1);
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready);
    int t;
    t = 0;
    while ((q_l.size() != 0 || q_s.size() != 0) && t < budget) begin
      if (rnd_ready) txready = ($urandom_range(0, 3) != 0);
      tick();
      t++;
    end
    txready = 1'b1;
    chk("bytes_left", q_l.size() + q_s.size(), 0);
    q_l.delete();
    q_s.delete();
    tick();
    tick();
    chk("done_busy_l", busy_l, 0);
    chk("done_busy_s", busy_s, 0);
  endtask

  task automatic wait_pulses(input int target);
    int t;
    t = 0;
    while (n_pulse_l < target && t < 200) begin
      tick();
      t++;
    end
    chk("pulse_wait", (n_pulse_l >= target), 1);
  endtask

  task automatic end_game();
    state = 3'b000;
    tick();
    m_nb = 1'b0;
    chk("idle_new_best_l", new_best_l, 0);
    chk("idle_new_best_s", new_best_s, 0);
  endtask

  task automatic quiet_window(input string tag);
    int p0;
    bit seen_busy;
    p0 = n_pulse_l + n_pulse_s;
    seen_busy = 1'b0;
    repeat (50) begin
      tick();
      if (busy_l || busy_s) seen_busy = 1'b1;
    end
    chk({tag, "_pulses"}, n_pulse_l + n_pulse_s - p0, 0);
    chk({tag, "_busy"}, seen_busy, 0);
  endtask

  initial begin
    int p0;
    logic [7:0] sc;

    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Game 1: score 42 on a fresh board, txready held high.
    trigger_game(8'h42);
    wait_idle(200, 1'b0);
    chk("g1_pulses", pc_l.size(), 18);
    if (pc_l.size() == 18) begin
      chk("g1_first_txclk", pc_l[0], trig_cyc + 2);
      for (int i = 1; i < 18; i++) chk("g1_byte_period", pc_l[i] - pc_l[i-1], 2);
    end
    chk("g1_best", best_l, 8'h42);
    chk("g1_new_best", new_best_l, 1);
    end_game();

    // Game 2: score 55 keeps best 42; txready drops after 'O' has gone out.
    trigger_game(8'h55);
    p0 = n_pulse_l - pc_l.size();
    wait_pulses(p0 + 3);
    txready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_txclk_l", txclk_l, 0);
      chk("stall_txdata_l", txdata_l, 8'h4F);
      chk("stall_txclk_s", txclk_s, 0);
    end
    txready = 1'b1;
    tick();
    chk("resume_txclk_l", txclk_l, 1);
    chk("resume_txdata_l", txdata_l, 8'h52);
    wait_idle(200, 1'b0);
    chk("g2_best", best_l, 8'h42);
    chk("g2_new_best", new_best_l, 0);
    end_game();

    // Game 3: reset lands just before byte 5 would be loaded.
    trigger_game(8'h31);
    p0 = n_pulse_l - pc_l.size();
    wait_pulses(p0 + 4);
    tick();
    rst = 1'b1;
    tick();
    q_l.delete();
    q_s.delete();
    m_best = 8'h99;
    m_nb = 1'b0;
    check_reset_vals("midrst");
    rst = 1'b0;
    quiet_window("midrst_quiet");

    // Reset released while state already reads game-over.
    state = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    state = 3'b111;
    tick();
    tick();
    rst = 1'b0;
    quiet_window("over_at_rst");
    end_game();

    // Randomized games, some with a retrigger attempt while busy.
    for (int g = 0; g < 30; g++) begin
      if ($urandom_range(0, 3) == 0) sc = 8'($urandom);
      else sc = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      trigger_game(sc);
      if ($urandom_range(0, 2) == 0) begin
        p0 = n_pulse_l - pc_l.size();
        wait_pulses(p0 + 2);
        state = 3'b000;
        tick();
        m_nb = 1'b0;
        chk("retrig_new_best_l", new_best_l, 0);
        chk("retrig_new_best_s", new_best_s, 0);
        state = 3'b111;
        tick();
      end
      wait_idle(400, 1'b1);
      chk("rnd_best_l", best_l, m_best);
      chk("rnd_best_s", best_s, m_best);
      end_game();
    end

    // Short message: score 07.
    p0 = n_pulse_s;
    trigger_game(8'h07);
    wait_idle(200, 1'b0);
    chk("short_pulses", n_pulse_s - p0, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
